// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: default widths, reset PC and FSM state encoding.
package fetch_unit_pkg;

  localparam int          FU_WORD_SIZE = 16;
  localparam logic [15:0] FU_RESET_PC  = 16'h0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, next-PC mux, imem handshake FSM,
// stall hold buffer and IF/ID pipeline register.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                   WORD_SIZE = FU_WORD_SIZE,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = WORD_SIZE'(FU_RESET_PC)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 stall_if,
  input  logic                 redirect,
  input  logic [WORD_SIZE-1:0] redirect_pc,
  input  logic [WORD_SIZE-1:0] bp_predicted_pc,
  input  logic                 bp_tag_match,
  output logic [WORD_SIZE-1:0] pc_fetch,
  output logic                 imem_req,
  input  logic                 imem_ready,
  input  logic [WORD_SIZE-1:0] imem_data,
  output logic                 if_id_valid,
  output logic [WORD_SIZE-1:0] if_id_pc,
  output logic [WORD_SIZE-1:0] if_id_inst,
  output logic [WORD_SIZE-1:0] if_id_pred_pc,
  output logic                 if_id_pred_taken
);

  fetch_state_t         state, state_d;
  logic [WORD_SIZE-1:0] pc_d, pending, pending_d;
  logic [WORD_SIZE-1:0] hold_inst, hold_inst_d, hold_pred, hold_pred_d;
  logic                 hold_taken, hold_taken_d;
  logic                 if_id_valid_d, if_id_pred_taken_d;
  logic [WORD_SIZE-1:0] if_id_pc_d, if_id_inst_d, if_id_pred_pc_d;
  logic [WORD_SIZE-1:0] seq_pc, next_pc;

  assign seq_pc   = pc_fetch + WORD_SIZE'(1);
  assign next_pc  = bp_tag_match ? bp_predicted_pc : seq_pc;
  assign imem_req = reset_n && (state != HOLD);

  always_comb begin
    // NOTE: combinational logic uses blocking '=' and gives every target a
    // default first, so no path can leave a value unassigned and infer a latch.
    state_d            = state;
    pc_d               = pc_fetch;
    pending_d          = pending;
    hold_inst_d        = hold_inst;
    hold_pred_d        = hold_pred;
    hold_taken_d       = hold_taken;
    if_id_valid_d      = if_id_valid;
    if_id_pc_d         = if_id_pc;
    if_id_inst_d       = if_id_inst;
    if_id_pred_pc_d    = if_id_pred_pc;
    if_id_pred_taken_d = if_id_pred_taken;

    case (state)
      FETCH: begin
        if (redirect) begin
          if_id_valid_d = 1'b0;
          if (imem_ready) begin
            pc_d = redirect_pc;
          end else begin
            // Response for the stale PC is still owed; wait for it in DRAIN.
            pending_d = redirect_pc;
            state_d   = DRAIN;
          end
        end else if (imem_ready) begin
          if (!stall_if) begin
            if_id_valid_d      = 1'b1;
            if_id_pc_d         = pc_fetch;
            if_id_inst_d       = imem_data;
            if_id_pred_pc_d    = next_pc;
            if_id_pred_taken_d = bp_tag_match;
            pc_d               = next_pc;
          end else begin
            hold_inst_d  = imem_data;
            hold_pred_d  = next_pc;
            hold_taken_d = bp_tag_match;
            state_d      = HOLD;
          end
        end else if (!stall_if) begin
          if_id_valid_d = 1'b0;
        end
      end

      HOLD: begin
        if (redirect) begin
          if_id_valid_d = 1'b0;
          pc_d          = redirect_pc;
          state_d       = FETCH;
        end else if (!stall_if) begin
          if_id_valid_d      = 1'b1;
          if_id_pc_d         = pc_fetch;
          if_id_inst_d       = hold_inst;
          if_id_pred_pc_d    = hold_pred;
          if_id_pred_taken_d = hold_taken;
          pc_d               = hold_pred;
          state_d            = FETCH;
        end
      end

      DRAIN: begin
        if_id_valid_d = 1'b0;
        if (imem_ready) begin
          pc_d    = redirect ? redirect_pc : pending;
          state_d = FETCH;
        end else if (redirect) begin
          pending_d = redirect_pc;
        end
      end

      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // pre-edge values regardless of statement order.
    if (!reset_n) begin
      state            <= FETCH;
      pc_fetch         <= RESET_PC;
      pending          <= '0;
      hold_inst        <= '0;
      hold_pred        <= '0;
      hold_taken       <= 1'b0;
      if_id_valid      <= 1'b0;
      if_id_pc         <= '0;
      if_id_inst       <= '0;
      if_id_pred_pc    <= '0;
      if_id_pred_taken <= 1'b0;
    end else begin
      state            <= state_d;
      pc_fetch         <= pc_d;
      pending          <= pending_d;
      hold_inst        <= hold_inst_d;
      hold_pred        <= hold_pred_d;
      hold_taken       <= hold_taken_d;
      if_id_valid      <= if_id_valid_d;
      if_id_pc         <= if_id_pc_d;
      if_id_inst       <= if_id_inst_d;
      if_id_pred_pc    <= if_id_pred_pc_d;
      if_id_pred_taken <= if_id_pred_taken_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: transaction-level fetch model feeds a
// scoreboard queue; a separate monitor compares every IF/ID update.
module tb_fetch_unit;

  localparam int          WS  = 16;
  localparam logic [15:0] RPC = 16'h0000;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          stall_if = 1'b0, redirect = 1'b0;
  logic [WS-1:0] redirect_pc = '0, bp_predicted_pc = '0;
  logic          bp_tag_match = 1'b0;
  logic [WS-1:0] pc_fetch;
  logic          imem_req;
  logic          imem_ready = 1'b0;
  logic [WS-1:0] imem_data = '0;
  logic          if_id_valid, if_id_pred_taken;
  logic [WS-1:0] if_id_pc, if_id_inst, if_id_pred_pc;

  fetch_unit #(.WORD_SIZE(WS), .RESET_PC(RPC)) dut (
    .clk(clk), .reset_n(reset_n), .stall_if(stall_if), .redirect(redirect),
    .redirect_pc(redirect_pc), .bp_predicted_pc(bp_predicted_pc),
    .bp_tag_match(bp_tag_match), .pc_fetch(pc_fetch), .imem_req(imem_req),
    .imem_ready(imem_ready), .imem_data(imem_data), .if_id_valid(if_id_valid),
    .if_id_pc(if_id_pc), .if_id_inst(if_id_inst), .if_id_pred_pc(if_id_pred_pc),
    .if_id_pred_taken(if_id_pred_taken)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] inst;
    logic [15:0] pred;
    logic        taken;
  } entry_t;

  entry_t sb[$];
  int checks = 0;
  int errors = 0;

  // Reference model: where fetch should be, whether a response is owed to a
  // redirected-away PC, and whether an accepted instruction is parked.
  logic [15:0] exp_pc = RPC;
  logic        parked = 1'b0, discard = 1'b0;
  logic [15:0] pending = '0;
  entry_t      park_e;

  function automatic logic [15:0] inst_of(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus: drive at negedge, check PC/request, advance model.
  task automatic step(input logic rn, input logic st, input logic rd,
                      input logic [15:0] rpc, input logic rdy_in,
                      input logic tg, input logic [15:0] ppc);
    logic        rdy;
    logic [15:0] np;
    entry_t      e;
    @(negedge clk);
    rdy             = rdy_in && rn && !parked;
    reset_n         = rn;
    stall_if        = st;
    redirect        = rd;
    redirect_pc     = rpc;
    bp_tag_match    = tg;
    bp_predicted_pc = ppc;
    imem_ready      = rdy;
    imem_data       = inst_of(pc_fetch);
    #1;
    check("pc_fetch", 32'(pc_fetch), 32'(exp_pc));
    check("imem_req", 32'(imem_req), 32'(rn && !parked));
    if (!rn) begin
      exp_pc = RPC; parked = 1'b0; discard = 1'b0; pending = '0;
    end else if (parked) begin
      if (rd) begin
        exp_pc = rpc; parked = 1'b0;
      end else if (!st) begin
        sb.push_back(park_e); exp_pc = park_e.pred; parked = 1'b0;
      end
    end else if (discard) begin
      if (rdy) begin
        exp_pc = rd ? rpc : pending; discard = 1'b0;
      end else if (rd) begin
        pending = rpc;
      end
    end else if (rd) begin
      if (rdy) exp_pc = rpc;
      else begin discard = 1'b1; pending = rpc; end
    end else if (rdy) begin
      np = exp_pc + 16'd1;
      if (tg) np = ppc;
      e  = '{pc: exp_pc, inst: inst_of(exp_pc), pred: np, taken: tg};
      if (!st) begin sb.push_back(e); exp_pc = np; end
      else begin park_e = e; parked = 1'b1; end
    end
  endtask

  // Monitor: after every edge, derive the expected IF/ID from the scoreboard.
  logic   mv = 1'b0;
  entry_t me = '{pc: '0, inst: '0, pred: '0, taken: 1'b0};

  initial begin
    logic rn_s, st_s, rd_s;
    forever begin
      @(posedge clk);
      rn_s = reset_n; st_s = stall_if; rd_s = redirect;
      #1;
      if (!rn_s || rd_s) mv = 1'b0;
      else if (!st_s) begin
        if (sb.size() > 0) begin me = sb.pop_front(); mv = 1'b1; end
        else mv = 1'b0;
      end
      check("if_id_valid", 32'(if_id_valid), 32'(mv));
      if (mv && if_id_valid) begin
        check("if_id_pc", 32'(if_id_pc), 32'(me.pc));
        check("if_id_inst", 32'(if_id_inst), 32'(me.inst));
        check("if_id_pred_pc", 32'(if_id_pred_pc), 32'(me.pred));
        check("if_id_pred_taken", 32'(if_id_pred_taken), 32'(me.taken));
      end
    end
  end

  initial begin
    // Reset, then zero-wait sequential fetch.
    step(0, 0, 0, 16'h0, 0, 0, 16'h0);
    step(0, 0, 0, 16'h0, 0, 0, 16'h0);
    repeat (4) step(1, 0, 0, 16'h0, 1, 0, 16'h0);
    // Redirect to 0x0005 with an immediate response, then a BTB hit to 0x0040.
    step(1, 0, 1, 16'h0005, 1, 0, 16'h0);
    step(1, 0, 0, 16'h0, 1, 1, 16'h0040);
    step(1, 0, 0, 16'h0, 1, 0, 16'h0);
    // Memory three cycles late.
    repeat (3) step(1, 0, 0, 16'h0, 0, 0, 16'h0);
    step(1, 0, 0, 16'h0, 1, 0, 16'h0);
    // Response arrives under a 4-cycle stall, then release.
    step(1, 1, 0, 16'h0, 1, 1, 16'h0777);
    repeat (3) step(1, 1, 0, 16'h0, 0, 0, 16'h0);
    step(1, 0, 0, 16'h0, 0, 0, 16'h0);
    step(1, 0, 0, 16'h0, 1, 0, 16'h0);
    // Redirect while outstanding: response two cycles later is discarded.
    step(1, 0, 1, 16'h0100, 0, 0, 16'h0);
    step(1, 0, 0, 16'h0, 0, 0, 16'h0);
    step(1, 0, 0, 16'h0, 1, 0, 16'h0);
    step(1, 0, 0, 16'h0, 1, 0, 16'h0);
    // PC wrap at 0xFFFF.
    step(1, 0, 1, 16'hFFFF, 1, 0, 16'h0);
    step(1, 0, 0, 16'h0, 1, 0, 16'h0);
    step(1, 0, 0, 16'h0, 1, 0, 16'h0);
    // Reset in the middle of a drain.
    step(1, 0, 1, 16'h0200, 0, 0, 16'h0);
    step(1, 0, 0, 16'h0, 0, 0, 16'h0);
    step(0, 0, 0, 16'h0, 0, 0, 16'h0);
    step(1, 0, 0, 16'h0, 1, 0, 16'h0);
    step(1, 0, 0, 16'h0, 1, 0, 16'h0);
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(99) != 0),
           ($urandom_range(3) == 0),
           ($urandom_range(9) == 0),
           16'($urandom),
           ($urandom_range(1) == 1),
           ($urandom_range(9) < 3),
           16'($urandom));
    end
    repeat (2) step(1, 1, 0, 16'h0, 0, 0, 16'h0);
    @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
